// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler: two buffered producers, round-robin onto one
// registered RF write port, plus a pending-write scoreboard for decode.
module regfile_wb_scheduler #(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 5,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] chk_a1,
  input  logic [ADDR_W-1:0] chk_a2,
  input  logic [ADDR_W-1:0] chk_a3,
  output logic              hazard,
  output logic [31:0]       busy_mask,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  logic [ADDR_W-1:0] r_addr [2][BUF_DEPTH];
  logic [DATA_W-1:0] r_data [2][BUF_DEPTH];
  logic [PW-1:0]     r_wp   [2];
  logic [PW-1:0]     r_rp   [2];
  logic [CW-1:0]     r_cnt  [2];
  src_e              r_last;

  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [31:0]       r_busy;

  logic [ADDR_W-1:0] w_in_addr [2];
  logic [DATA_W-1:0] w_in_data [2];
  logic [1:0]        w_ne;
  logic [1:0]        w_full;
  logic [1:0]        w_push;
  logic [1:0]        w_pop;
  logic              w_gnt;
  logic              w_sel;
  logic [ADDR_W-1:0] w_hd_addr;
  logic [DATA_W-1:0] w_hd_data;
  logic [31:0]       w_set;
  logic [31:0]       w_clr;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    w_in_addr[0] = alu_addr;
    w_in_addr[1] = lsu_addr;
    w_in_data[0] = alu_data;
    w_in_data[1] = lsu_data;
    for (int s = 0; s < 2; s++) begin
      w_ne[s]   = (r_cnt[s] != '0);
      w_full[s] = (r_cnt[s] == CW'(BUF_DEPTH));
    end
  end

  // ready comes from buffer occupancy only, never from same-cycle valid
  assign alu_ready = !w_full[0];
  assign lsu_ready = !w_full[1];
  assign w_push    = {lsu_valid & !w_full[1], alu_valid & !w_full[0]};

  always_comb begin
    w_pop = '0;
    unique case (w_ne)
      2'b01:   w_pop = 2'b01;
      2'b10:   w_pop = 2'b10;
      2'b11:   w_pop = (r_last == SRC_LSU) ? 2'b01 : 2'b10;
      default: w_pop = '0;
    endcase
  end

  assign w_gnt     = |w_pop;
  assign w_sel     = w_pop[1];
  assign w_hd_addr = r_addr[w_sel][r_rp[w_sel]];
  assign w_hd_data = r_data[w_sel][r_rp[w_sel]];

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (w_push[s]) begin
        r_addr[s][r_wp[s]] <= w_in_addr[s];
        r_data[s][r_wp[s]] <= w_in_data[s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        r_wp[s]  <= '0;
        r_rp[s]  <= '0;
        r_cnt[s] <= '0;
      end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (w_push[s]) r_wp[s] <= f_inc(r_wp[s]);
        if (w_pop[s])  r_rp[s] <= f_inc(r_rp[s]);
        r_cnt[s] <= r_cnt[s] + CW'(w_push[s]) - CW'(w_pop[s]);
      end
    end
  end

  // an addr-0 grant is consumed and advances the pointer, but never writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= SRC_LSU;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_gnt) begin
      r_last  <= src_e'(w_sel);
      r_we    <= (w_hd_addr != '0);
      r_waddr <= w_hd_addr;
      r_wdata <= w_hd_data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_valid && issue_rd != '0) w_set = 32'd1 << issue_rd;
    if (r_we)                          w_clr = 32'd1 << r_waddr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
  end

  assign hazard    = r_busy[chk_a1] | r_busy[chk_a2] | r_busy[chk_a3];
  assign busy_mask = r_busy;
  assign rf_we     = r_we;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;

endmodule
